// File: rtl/div_arbiter.sv
// div_arbiter: round-robin front end that shares one 12/6-bit restoring
// divider between N_REQ requesters. Operands are screened at grant time so
// that divide-by-zero and quotient overflow never reach the divider; valid
// jobs are sequenced through the divider's start/ready handshake with a
// watchdog that aborts a hung divide.
module div_arbiter #(
    parameter int N_REQ        = 4,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [12*N_REQ-1:0]  req_aq,
    input  logic [6*N_REQ-1:0]   req_div,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     done,
    output logic [5:0]           res_q,
    output logic [5:0]           res_r,
    output logic [1:0]           res_err,
    output logic                 busy,
    output logic                 div_start,
    output logic [11:0]          div_aq,
    output logic [5:0]           div_div,
    input  logic [5:0]           div_quotient,
    input  logic [5:0]           div_remainder,
    input  logic                 div_ready
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int SC_W  = $clog2(START_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_DIVZERO = 2'd1;
    localparam logic [1:0] ERR_OVF     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESP      = 3'd4
    } state_t;

    state_t               state_r, state_s;
    logic [IDX_W-1:0]     rr_ptr_r, rr_ptr_s;
    logic [IDX_W-1:0]     win_r, win_s;
    logic [N_REQ-1:0]     gnt_r, gnt_s, done_r, done_s;
    logic [5:0]           res_q_r, res_q_s, res_r_r, res_r_s;
    logic [1:0]           err_r, err_s;
    logic                 div_start_r, div_start_s;
    logic [11:0]          aq_r, aq_s;
    logic [5:0]           dv_r, dv_s;
    logic [SC_W-1:0]      sc_cnt_r, sc_cnt_s;
    logic [TO_W-1:0]      to_cnt_r, to_cnt_s;

    logic [2*N_REQ-1:0]   req_dbl_s;
    logic [N_REQ-1:0]     req_rot_s;
    logic [IDX_W-1:0]     pick_off_s, pick_s;
    logic [IDX_W:0]       pick_sum_s;
    logic                 pick_vld_s;
    logic [11:0]          sel_aq_s;
    logic [5:0]           sel_dv_s;
    logic [1:0]           scr_err_s;
    logic [N_REQ-1:0]     pick_oh_s;

    // Classify operands before they are handed to the divider: a zero divisor
    // or a dividend whose upper seven bits reach the divisor cannot be divided.
    function automatic logic [1:0] screen_err(input logic [11:0] aq, input logic [5:0] dv);
        logic [1:0] err;
        if (dv == 6'd0) begin
            err = ERR_DIVZERO;
        end else if (aq[11:5] >= {1'b0, dv}) begin
            err = ERR_OVF;
        end else begin
            err = ERR_OK;
        end
        return err;
    endfunction

    // Round-robin pick: rotate req so the pointer lands at bit 0, take the
    // lowest set bit, then translate the offset back to a requester index.
    always_comb begin
        req_dbl_s  = {req, req};
        req_rot_s  = req_dbl_s[rr_ptr_r +: N_REQ];
        pick_off_s = {IDX_W{1'b0}};
        pick_vld_s = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_rot_s[k]) begin
                pick_off_s = IDX_W'(k);
                pick_vld_s = 1'b1;
            end else begin
                pick_off_s = pick_off_s;
            end
        end
        pick_sum_s = {1'b0, rr_ptr_r} + {1'b0, pick_off_s};
        if (pick_sum_s >= (IDX_W+1)'(N_REQ)) begin
            pick_s = IDX_W'(pick_sum_s - (IDX_W+1)'(N_REQ));
        end else begin
            pick_s = pick_sum_s[IDX_W-1:0];
        end
        pick_oh_s = {{(N_REQ-1){1'b0}}, 1'b1} << pick_s;
        sel_aq_s  = 12'd0;
        sel_dv_s  = 6'd0;
        for (int k = 0; k < N_REQ; k++) begin
            if (pick_s == IDX_W'(k)) begin
                sel_aq_s = req_aq[12*k +: 12];
                sel_dv_s = req_div[6*k +: 6];
            end else begin
                sel_aq_s = sel_aq_s;
            end
        end
        scr_err_s = screen_err(sel_aq_s, sel_dv_s);
    end

    // Next-state and next-output logic for the service sequence.
    always_comb begin
        state_s     = state_r;
        rr_ptr_s    = rr_ptr_r;
        win_s       = win_r;
        gnt_s       = gnt_r;
        done_s      = done_r;
        res_q_s     = res_q_r;
        res_r_s     = res_r_r;
        err_s       = err_r;
        div_start_s = div_start_r;
        aq_s        = aq_r;
        dv_s        = dv_r;
        sc_cnt_s    = sc_cnt_r;
        to_cnt_s    = to_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_vld_s && div_ready) begin
                    win_s = pick_s;
                    gnt_s = pick_oh_s;
                    aq_s  = sel_aq_s;
                    dv_s  = sel_dv_s;
                    if (scr_err_s != ERR_OK) begin
                        state_s = ST_RESP;
                        done_s  = pick_oh_s;
                        err_s   = scr_err_s;
                        res_q_s = 6'd0;
                        res_r_s = 6'd0;
                    end else begin
                        state_s     = ST_START;
                        div_start_s = 1'b1;
                        sc_cnt_s    = {SC_W{1'b0}};
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (sc_cnt_r == SC_W'(START_CYCLES - 1)) begin
                    div_start_s = 1'b0;
                    state_s     = ST_WAIT_BUSY;
                    to_cnt_s    = {TO_W{1'b0}};
                end else begin
                    sc_cnt_s = sc_cnt_r + SC_W'(1);
                end
            end
            ST_WAIT_BUSY: begin
                if (to_cnt_r == TO_W'(TIMEOUT - 1)) begin
                    state_s = ST_RESP;
                    done_s  = gnt_r;
                    err_s   = ERR_TIMEOUT;
                    res_q_s = 6'd0;
                    res_r_s = 6'd0;
                end else if (!div_ready) begin
                    state_s  = ST_WAIT_DONE;
                    to_cnt_s = to_cnt_r + TO_W'(1);
                end else begin
                    to_cnt_s = to_cnt_r + TO_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (div_ready) begin
                    state_s = ST_RESP;
                    done_s  = gnt_r;
                    err_s   = ERR_OK;
                    res_q_s = div_quotient;
                    res_r_s = div_remainder;
                end else if (to_cnt_r == TO_W'(TIMEOUT - 1)) begin
                    state_s = ST_RESP;
                    done_s  = gnt_r;
                    err_s   = ERR_TIMEOUT;
                    res_q_s = 6'd0;
                    res_r_s = 6'd0;
                end else begin
                    to_cnt_s = to_cnt_r + TO_W'(1);
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
                gnt_s   = {N_REQ{1'b0}};
                done_s  = {N_REQ{1'b0}};
                res_q_s = 6'd0;
                res_r_s = 6'd0;
                err_s   = ERR_OK;
                if (win_r == IDX_W'(N_REQ - 1)) begin
                    rr_ptr_s = {IDX_W{1'b0}};
                end else begin
                    rr_ptr_s = win_r + IDX_W'(1);
                end
            end
            default: begin
                state_s     = ST_IDLE;
                gnt_s       = {N_REQ{1'b0}};
                done_s      = {N_REQ{1'b0}};
                div_start_s = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered datapath, pointer, counters and all client/divider outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r    <= {IDX_W{1'b0}};
            win_r       <= {IDX_W{1'b0}};
            gnt_r       <= {N_REQ{1'b0}};
            done_r      <= {N_REQ{1'b0}};
            res_q_r     <= 6'd0;
            res_r_r     <= 6'd0;
            err_r       <= 2'd0;
            div_start_r <= 1'b0;
            aq_r        <= 12'd0;
            dv_r        <= 6'd0;
            sc_cnt_r    <= {SC_W{1'b0}};
            to_cnt_r    <= {TO_W{1'b0}};
        end else begin
            rr_ptr_r    <= rr_ptr_s;
            win_r       <= win_s;
            gnt_r       <= gnt_s;
            done_r      <= done_s;
            res_q_r     <= res_q_s;
            res_r_r     <= res_r_s;
            err_r       <= err_s;
            div_start_r <= div_start_s;
            aq_r        <= aq_s;
            dv_r        <= dv_s;
            sc_cnt_r    <= sc_cnt_s;
            to_cnt_r    <= to_cnt_s;
        end
    end

    assign gnt       = gnt_r;
    assign done      = done_r;
    assign res_q     = res_q_r;
    assign res_r     = res_r_r;
    assign res_err   = err_r;
    assign busy      = (state_r != ST_IDLE);
    assign div_start = div_start_r;
    assign div_aq    = aq_r;
    assign div_div   = dv_r;

endmodule
